cpu_trace_emitter: RTL and testbench
====================================

CPU_TRACE_EMITTER -- requirements
Module: cpu_trace_emitter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: a trace record is presented.
REQ-004 SHALL have port in_ready, output, 1 bit: a record is accepted when in_valid && in_ready at posedge.
REQ-005 SHALL have port kind, input, 1 bit: 0 = register write, 1 = memory write.
REQ-006 SHALL have port time_val, input, 14 bits: time stamp, binary.
REQ-007 SHALL have port pc, input, 32 bits: instruction address.
REQ-008 SHALL have port reg_num, input, 14 bits: register number, binary; used when kind=0.
REQ-009 SHALL have port addr, input, 32 bits: memory address; used when kind=1.
REQ-010 SHALL have port data, input, 32 bits: written value.
REQ-011 SHALL have port char_out, output, 8 bits: ASCII character.
REQ-012 SHALL have port char_valid, output, 1 bit: char_out is valid.
REQ-013 SHALL have port char_ready, input, 1 bit: a character is consumed when char_valid && char_ready at posedge.

Function
REQ-014 SHALL serialise each accepted record into one line: "^" T "@" P8 ":" then, for kind=0, "$" R "<=" D8 "#", or for kind=1, "*" A8 "<=" D8 "#".
REQ-015 SHALL emit T and R as 1-4 decimal digits with no leading zeros; value 0 emits "0".
REQ-016 SHALL clamp T and R values above 9999 to 9999.
REQ-017 SHALL emit P8, A8 and D8 as exactly 8 lowercase hex digits, MSB first, zero-padded.
REQ-018 SHALL register all record fields on accept; later input changes SHALL NOT affect the line in progress.
REQ-019 SHALL drive in_ready=1 only in state IDLE; in_ready SHALL be combinational from state only.
REQ-020 SHALL implement the FSM states IDLE, CARET, TIME, AT, PC, COLON, SP_A, SIGIL, FIELD, SP_B, LT, EQ, SP_C, DATA, HASH, using a digit counter for TIME, PC, FIELD and DATA.
REQ-021 SHALL enter CARET on the cycle after accept and assert char_valid with "^"; there are no idle cycles between characters.
REQ-022 SHALL hold char_out and char_valid stable while char_ready=0.
REQ-023 SHALL advance to the next character only on a handshake.
REQ-024 SHALL move to IDLE after "#" is consumed, with in_ready=1 in the following cycle; this gives one bubble cycle between lines.
REQ-025 SHALL hold char_valid=0 in IDLE.
REQ-026 SHALL keep char_out a registered output.

Reset
REQ-027 SHALL, while reset=0, force state=IDLE, char_valid=0, char_out=8'h00, in_ready=1 and all counters/field registers to 0.
REQ-028 SHALL abandon a line in progress when reset is asserted mid-line; no partial-line continuation SHALL occur after release.

Configuration
REQ-029 SHALL support macro CPU_TRACE_SPACES_EN: when defined, states SP_A, SP_B and SP_C each emit exactly one " " (after ":", before "<", after "=").
REQ-030 SHALL, when CPU_TRACE_SPACES_EN is undefined, skip SP_A, SP_B and SP_C entirely, with no extra cycles.

Structure
REQ-031 SHALL place in package cpu_trace_pkg: ASCII character constants, the FSM state enum, and a 4-bit-to-lowercase-hex function.
REQ-032 SHALL use one sub-module trace_bcd4 (combinational, 14-bit binary clamped to 4 BCD digits plus digit count 1-4), instantiated twice (time, reg).

Verification
REQ-033 SHALL cover: spaces off, kind=0, time 10, pc 0x00003000, reg 1, data 0x0000abcd, char_ready=1 -> "^10@00003000:$1<=0000abcd#" in 26 consecutive valid cycles, then in_ready=1.
REQ-034 SHALL cover: spaces on, kind=1, time 0, pc 0x00003004, addr 0x00001004, data 0xffffffff -> "^0@00003004: *00001004 <= ffffffff#".
REQ-035 SHALL cover: time 12345, reg 0 -> T field "9999" and R field "0".
REQ-036 SHALL cover: char_ready toggled randomly (for example, low for 3 cycles on "@") -> identical character sequence, char_out stable while stalled, and in_ready=0 throughout the line.
REQ-037 SHALL cover: reset pulsed low on the 5th character -> char_valid=0 immediately; after release, in_ready=1 and the next record starts with "^".
REQ-038 SHALL cover: two back-to-back records with in_valid held high -> second "^" appears exactly 2 cycles after the first "#" handshake.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg
//   Shared definitions for the trace emitter:
//   - ASCII character constants used in a trace line
//   - FSM state enum (one state per field/character class)
//   - record struct captured on accept
//   - hex_char: 4-bit value -> lowercase ASCII hex digit
//   - nib8: select nibble 0..7 of a 32-bit word (nibble 7 = MSB)
package cpu_trace_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5e;  // '^'
  localparam logic [7:0] CH_AT     = 8'h40;  // '@'
  localparam logic [7:0] CH_COLON  = 8'h3a;  // ':'
  localparam logic [7:0] CH_SP     = 8'h20;  // ' '
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$'
  localparam logic [7:0] CH_STAR   = 8'h2a;  // '*'
  localparam logic [7:0] CH_LT     = 8'h3c;  // '<'
  localparam logic [7:0] CH_EQ     = 8'h3d;  // '='
  localparam logic [7:0] CH_HASH   = 8'h23;  // '#'
  localparam logic [7:0] CH_ZERO   = 8'h30;  // '0'
  localparam logic [7:0] CH_LA     = 8'h61;  // 'a'

  typedef enum logic [3:0] {
    IDLE, CARET, TIME, AT, PC, COLON, SP_A, SIGIL,
    FIELD, SP_B, LT, EQ, SP_C, DATA, HASH
  } state_e;

  // fld holds the zero-extended register number (kind=0) or the address (kind=1)
  typedef struct packed {
    logic        kind;
    logic [13:0] tval;
    logic [31:0] pc;
    logic [31:0] fld;
    logic [31:0] data;
  } rec_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = CH_ZERO + {4'h0, n};
    else           c = CH_LA + {4'h0, n} - 8'd10;
    return c;
  endfunction

  function automatic logic [3:0] nib8(input logic [31:0] w, input logic [2:0] i);
    logic [3:0] r;
    r = w[3:0];
    case (i)
      3'd0: r = w[3:0];
      3'd1: r = w[7:4];
      3'd2: r = w[11:8];
      3'd3: r = w[15:12];
      3'd4: r = w[19:16];
      3'd5: r = w[23:20];
      3'd6: r = w[27:24];
      3'd7: r = w[31:28];
      default: r = w[3:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/trace_bcd4.sv
// trace_bcd4
//   Combinational 14-bit binary to 4-digit BCD converter. Values above 9999
//   are clamped to 9999. ndig_o gives the number of significant digits
//   (1..4, value 0 counts as one digit).
//   Ports:
//     bin_i  [13:0]      binary input
//     dig_o  [3:0][3:0]  BCD digits, dig_o[3] = thousands
//     ndig_o [2:0]       significant digit count, 1..4
module trace_bcd4 (
  input  logic [13:0]      bin_i,
  output logic [3:0][3:0]  dig_o,
  output logic [2:0]       ndig_o
);

  logic [13:0] v;

  always_comb begin
    v        = (bin_i > 14'd9999) ? 14'd9999 : bin_i;
    dig_o[3] = 4'(v / 14'd1000);
    dig_o[2] = 4'((v / 14'd100) % 14'd10);
    dig_o[1] = 4'((v / 14'd10) % 14'd10);
    dig_o[0] = 4'(v % 14'd10);
    if (v >= 14'd1000)     ndig_o = 3'd4;
    else if (v >= 14'd100) ndig_o = 3'd3;
    else if (v >= 14'd10)  ndig_o = 3'd2;
    else                   ndig_o = 3'd1;
  end

endmodule

// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter
//   Serialises CPU trace records into ASCII lines, one character per
//   handshake:
//     kind=0: ^T@PPPPPPPP:$R<=DDDDDDDD#
//     kind=1: ^T@PPPPPPPP:*AAAAAAAA<=DDDDDDDD#
//   T and R are 1-4 decimal digits (clamped to 9999), P/A/D are 8 lowercase
//   hex digits. Build option CPU_TRACE_SPACES_EN inserts one space after ':',
//   before '<' and after '='.
//   Ports:
//     clk, reset (async, active low)
//     in_valid/in_ready     record handshake; in_ready only in IDLE
//     kind, time_val, pc, reg_num, addr, data   record fields
//     char_out/char_valid/char_ready           character stream handshake
module cpu_trace_emitter
  import cpu_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        kind,
  input  logic [13:0] time_val,
  input  logic [31:0] pc,
  input  logic [13:0] reg_num,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready
);

`ifdef CPU_TRACE_SPACES_EN
  localparam logic SPACES_EN = 1'b1;
`else
  localparam logic SPACES_EN = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;     // digit index, counts down to 0 (MSB first)
  rec_t        rec_q;
  logic [7:0]  char_q, char_d;
  logic        vld_q;

  logic [3:0][3:0] t_dig, r_dig;
  logic [2:0]      t_ndig, r_ndig;

  trace_bcd4 u_bcd_time (.bin_i(rec_q.tval),      .dig_o(t_dig), .ndig_o(t_ndig));
  trace_bcd4 u_bcd_reg  (.bin_i(rec_q.fld[13:0]), .dig_o(r_dig), .ndig_o(r_ndig));

  assign in_ready   = (state_q == IDLE);
  assign char_out   = char_q;
  assign char_valid = vld_q;

  // Successor of the character currently on char_out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CARET: begin state_d = TIME; cnt_d = t_ndig - 3'd1; end
      TIME:  if (cnt_q == 3'd0) state_d = AT; else cnt_d = cnt_q - 3'd1;
      AT:    begin state_d = PC; cnt_d = 3'd7; end
      PC:    if (cnt_q == 3'd0) state_d = COLON; else cnt_d = cnt_q - 3'd1;
      COLON: state_d = SPACES_EN ? SP_A : SIGIL;
      SP_A:  state_d = SIGIL;
      SIGIL: begin
        state_d = FIELD;
        cnt_d   = rec_q.kind ? 3'd7 : (r_ndig - 3'd1);
      end
      FIELD: if (cnt_q == 3'd0) state_d = SPACES_EN ? SP_B : LT;
             else cnt_d = cnt_q - 3'd1;
      SP_B:  state_d = LT;
      LT:    state_d = EQ;
      EQ:    begin state_d = SPACES_EN ? SP_C : DATA; cnt_d = 3'd7; end
      SP_C:  begin state_d = DATA; cnt_d = 3'd7; end
      DATA:  if (cnt_q == 3'd0) state_d = HASH; else cnt_d = cnt_q - 3'd1;
      HASH:  begin state_d = IDLE; cnt_d = 3'd0; end
      default: begin state_d = IDLE; cnt_d = 3'd0; end
    endcase
  end

  // Character for the successor state, so char_out can be registered.
  always_comb begin
    char_d = 8'h00;
    case (state_d)
      CARET: char_d = CH_CARET;
      TIME:  char_d = CH_ZERO + {4'h0, t_dig[cnt_d[1:0]]};
      AT:    char_d = CH_AT;
      PC:    char_d = hex_char(nib8(rec_q.pc, cnt_d));
      COLON: char_d = CH_COLON;
      SP_A, SP_B, SP_C: char_d = CH_SP;
      SIGIL: char_d = rec_q.kind ? CH_STAR : CH_DOLLAR;
      FIELD: char_d = rec_q.kind ? hex_char(nib8(rec_q.fld, cnt_d))
                                 : CH_ZERO + {4'h0, r_dig[cnt_d[1:0]]};
      LT:    char_d = CH_LT;
      EQ:    char_d = CH_EQ;
      DATA:  char_d = hex_char(nib8(rec_q.data, cnt_d));
      HASH:  char_d = CH_HASH;
      default: char_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rec_q   <= '0;
      char_q  <= 8'h00;
      vld_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        rec_q.kind <= kind;
        rec_q.tval <= time_val;
        rec_q.pc   <= pc;
        rec_q.fld  <= kind ? addr : {18'h0, reg_num};
        rec_q.data <= data;
        state_q    <= CARET;
        cnt_q      <= 3'd0;
        char_q     <= CH_CARET;
        vld_q      <= 1'b1;
      end
    end else if (char_ready) begin
      // char_valid is high in every non-IDLE state, so ready alone is the handshake
      state_q <= state_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      vld_q   <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        kind = 1'b0;
  logic [13:0] time_val = '0;
  logic [31:0] pc = '0;
  logic [13:0] reg_num = '0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;
  logic        char_ready = 1'b1;
  logic        in_ready;
  logic [7:0]  char_out;
  logic        char_valid;

  cpu_trace_emitter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .time_val(time_val), .pc(pc), .reg_num(reg_num),
    .addr(addr), .data(data), .char_out(char_out), .char_valid(char_valid),
    .char_ready(char_ready)
  );

  always #5 clk = ~clk;

`ifdef CPU_TRACE_SPACES_EN
  localparam bit SP = 1'b1;
`else
  localparam bit SP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  byte   expq[$];
  string explines[$];
  string gotlines[$];
  string cur = "";
  string cur_exp = "";
  int    cyc = 0;
  int    hash_cyc = -1;
  int    start_cyc = -1;
  bit    prev_vld = 0, prev_rdy = 0;
  logic [7:0] prev_char = 8'h00;

  // char_ready driver controls
  bit         rnd = 0;
  logic [7:0] stall_ch = 8'h00;
  int         stall_left = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chks(input string nm, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=\"%s\" expected=\"%s\"", nm, act, exp);
    end
  endtask

  // Line the record must produce, straight from the formatting rules.
  function automatic string mk(input bit k, input int t, input logic [31:0] p,
                               input int r, input logic [31:0] a, input logic [31:0] d);
    string s, sp;
    sp = SP ? " " : "";
    if (t > 9999) t = 9999;
    if (r > 9999) r = 9999;
    s = $sformatf("^%0d@%08h:%s", t, p, sp);
    if (!k) s = {s, $sformatf("$%0d", r)};
    else    s = {s, $sformatf("*%08h", a)};
    s = {s, sp, "<=", sp, $sformatf("%08h#", d)};
    return s;
  endfunction

  // Compare process: checks every cycle at the negedge, then advances the model.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      chk("rst_char_valid", {63'd0, char_valid}, 64'd0);
      chk("rst_char_out", {56'd0, char_out}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      expq.delete();
      cur = "";
      cur_exp = "";
      prev_vld = 0;
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, expq.size() == 0});
      chk("char_valid", {63'd0, char_valid}, {63'd0, expq.size() != 0});
      if (expq.size() != 0) begin
        chk("char_out", {56'd0, char_out}, {56'd0, expq[0]});
        if (prev_vld && !prev_rdy) chk("stall_hold", {56'd0, char_out}, {56'd0, prev_char});
        if (!prev_vld) start_cyc = cyc;
      end
      prev_vld  = (expq.size() != 0);
      prev_rdy  = char_ready;
      prev_char = char_out;
      if (expq.size() != 0 && char_ready) begin
        cur = {cur, $sformatf("%c", char_out)};
        if (expq.pop_front() == 8'h23) begin
          hash_cyc = cyc;
          gotlines.push_back(cur);
          explines.push_back(cur_exp);
          cur = "";
        end
      end else if (expq.size() == 0 && in_valid) begin
        cur_exp = mk(kind, int'(time_val), pc, int'(reg_num), addr, data);
        for (int i = 0; i < cur_exp.len(); i++) expq.push_back(cur_exp[i]);
      end
    end
  end

  // char_ready driver: directed stall on a given character, random, or always 1
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0 && char_valid && char_out == stall_ch) begin
      char_ready = 1'b0;
      stall_left--;
    end else if (rnd) char_ready = 1'($urandom_range(0, 1));
    else char_ready = 1'b1;
  end

  // Present a record and return just after the accepting edge (in_valid still high).
  task automatic drive_wait(input bit k, input int t, input logic [31:0] p, input int r,
                            input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 0;
    kind = k; time_val = 14'(t); pc = p; reg_num = 14'(r); addr = a; data = d;
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout in_ready never rose");
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input bit k, input int t, input logic [31:0] p, input int r,
                      input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    drive_wait(k, t, p, r, a, d);
    in_valid = 1'b0;
    // scramble inputs: the line in progress must not see them
    kind = ~k; time_val = 14'($urandom); pc = $urandom; reg_num = 14'($urandom);
    addr = $urandom; data = $urandom;
  endtask

  task automatic finish_line(input string nm, input string lit, input bit use_lit);
    string g, e;
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #2;
      if (gotlines.size() > 0) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout no complete line", nm);
    end else begin
      g = gotlines.pop_front();
      e = explines.pop_front();
      chks({nm, "_model"}, g, e);
      if (use_lit) chks({nm, "_literal"}, g, lit);
    end
  endtask

  initial begin
    int h;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // basic register-write line, continuous ready
    send(0, 10, 32'h00003000, 1, 32'h0, 32'h0000abcd);
    finish_line("t1", SP ? "^10@00003000: $1 <= 0000abcd#" : "^10@00003000:$1<=0000abcd#", 1);
    chk("t1_valid_cycles", 64'(hash_cyc - start_cyc), SP ? 64'd28 : 64'd25);
    chk("t1_ready_after", {63'd0, in_ready}, 64'd1);

    // memory write, time 0, all-f data
    send(1, 0, 32'h00003004, 0, 32'h00001004, 32'hffffffff);
    finish_line("t2", SP ? "^0@00003004: *00001004 <= ffffffff#" : "^0@00003004:*00001004<=ffffffff#", 1);

    // clamping and zero register
    send(0, 12345, 32'h00000010, 0, 32'h0, 32'h12345678);
    finish_line("t3", SP ? "^9999@00000010: $0 <= 12345678#" : "^9999@00000010:$0<=12345678#", 1);
    send(0, 9999, 32'h0, 16383, 32'h0, 32'h0);
    finish_line("t3b", SP ? "^9999@00000000: $9999 <= 00000000#" : "^9999@00000000:$9999<=00000000#", 1);
    send(0, 100, 32'h89abcdef, 1000, 32'h0, 32'h00000009);
    finish_line("t3c", "", 0);

    // directed stall on '@' then random ready
    stall_ch = 8'h40; stall_left = 3;
    send(0, 7, 32'hdeadbeef, 42, 32'h0, 32'hcafef00d);
    finish_line("t4", SP ? "^7@deadbeef: $42 <= cafef00d#" : "^7@deadbeef:$42<=cafef00d#", 1);
    rnd = 1;
    send(1, 321, 32'h00400000, 0, 32'h7fff0001, 32'h0badc0de);
    finish_line("t4r1", "", 0);
    send(0, 5000, 32'h1, 77, 32'h0, 32'h80000000);
    finish_line("t4r2", "", 0);
    send(1, 16383, 32'hffffffff, 0, 32'h0, 32'h0);
    finish_line("t4r3", "", 0);
    rnd = 0;

    // reset on the 5th character
    send(0, 55, 32'h00000100, 3, 32'h0, 32'h11111111);
    begin
      bit ok;
      ok = 0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #2;
        if (cur.len() == 4) begin ok = 1; break; end
      end
      if (!ok) begin checks++; errors++; $display("FAIL rst_mid_timeout line did not reach 5th char"); end
    end
    reset = 1'b0;
    #1 chk("rst_mid_valid", {63'd0, char_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_mid_ready", {63'd0, in_ready}, 64'd1);
    send(0, 1, 32'h00000001, 2, 32'h0, 32'h00000003);
    finish_line("t5", SP ? "^1@00000001: $2 <= 00000003#" : "^1@00000001:$2<=00000003#", 1);

    // back-to-back records with in_valid held high
    @(posedge clk); #1;
    drive_wait(0, 1, 32'h00000020, 4, 32'h0, 32'h000000aa);
    drive_wait(1, 2, 32'h00000024, 0, 32'h00000800, 32'h000000bb);
    h = hash_cyc;
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("b2b_gap", 64'(start_cyc - h), 64'd2);
    finish_line("t6a", SP ? "^1@00000020: $4 <= 000000aa#" : "^1@00000020:$4<=000000aa#", 1);
    finish_line("t6b", SP ? "^2@00000024: *00000800 <= 000000bb#" : "^2@00000024:*00000800<=000000bb#", 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
